// File: rtl/sort4_if.sv
// sort4_if -- operand/result bundle for the four-operand sorter.
//
// Signals:
//   Start      request from the operand source (sampled while Busy=0)
//   D0..D3     4-bit unsigned operands, captured on an accepted Start
//   Busy       compare schedule running
//   Done       one-cycle pulse when Q0..Q3 hold the final result
//   Q0..Q3     working/result registers of the sorter
//   SwapCount  swaps performed by the last sort (0..6)
//
// Modports: master = operand source / consumer side, slave = sorter side.
interface sort4_if;
  logic       Start;
  logic [3:0] D0;
  logic [3:0] D1;
  logic [3:0] D2;
  logic [3:0] D3;
  logic       Busy;
  logic       Done;
  logic [3:0] Q0;
  logic [3:0] Q1;
  logic [3:0] Q2;
  logic [3:0] Q3;
  logic [2:0] SwapCount;

  modport master (
    output Start, D0, D1, D2, D3,
    input  Busy, Done, Q0, Q1, Q2, Q3, SwapCount
  );

  modport slave (
    input  Start, D0, D1, D2, D3,
    output Busy, Done, Q0, Q1, Q2, Q3, SwapCount
  );
endinterface

// File: rtl/sort4_sequencer.sv
// sort4_sequencer -- multi-cycle sorter for four 4-bit unsigned operands.
//
// One combinational magnitude comparator is time-shared over a fixed
// bubble-sort schedule of six compare/swap steps. A Start/Busy/Done
// handshake sits between the operand source and the consumer.
//
// Ports:
//   Clk    sole clock, rising edge
//   Reset  synchronous, active-high; returns everything to zero / IDLE
//   bus    sort4_if.slave: Start, D0..D3 in; Busy, Done, Q0..Q3,
//          SwapCount out
//
// Parameter:
//   DESCENDING  0: ascending result (swap when left > right)
//               1: descending result (swap when left < right)
module sort4_sequencer #(
  parameter bit DESCENDING = 1'b0
) (
  input  logic Clk,
  input  logic Reset,
  sort4_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Step 6 is a drain step: no compare, it only moves the FSM to DONE so
  // that Busy spans seven cycles and Done lands seven cycles after accept.
  localparam logic [2:0] LAST_STEP = 3'd6;

  state_t     state_q;
  logic [2:0] step_q;
  logic [3:0] r0_q, r1_q, r2_q, r3_q;
  logic [3:0] r0_d, r1_d, r2_d, r3_d;
  logic [2:0] swap_cnt_q;
  logic       busy_q;
  logic       done_q;

  logic [1:0] pair_sel;
  logic [3:0] cmp_a, cmp_b;
  logic       a_grt_b, a_ls_b, a_eq_b;
  logic       do_swap;

  // Schedule: pair 0 = (R0,R1), pair 1 = (R1,R2), pair 2 = (R2,R3)
  always_comb begin
    pair_sel = 2'd0;
    case (step_q)
      3'd0, 3'd3, 3'd5: pair_sel = 2'd0;
      3'd1, 3'd4:       pair_sel = 2'd1;
      3'd2:             pair_sel = 2'd2;
      default:          pair_sel = 2'd0;
    endcase
  end

  always_comb begin
    cmp_a = r0_q;
    cmp_b = r1_q;
    case (pair_sel)
      2'd1: begin
        cmp_a = r1_q;
        cmp_b = r2_q;
      end
      2'd2: begin
        cmp_a = r2_q;
        cmp_b = r3_q;
      end
      default: begin
        cmp_a = r0_q;
        cmp_b = r1_q;
      end
    endcase
  end

  // Shared magnitude comparator, purely combinational.
  always_comb begin
    a_grt_b = (cmp_a > cmp_b);
    a_ls_b  = (cmp_a < cmp_b);
    a_eq_b  = (cmp_a == cmp_b);
  end

  // Equal operands never swap, which keeps the sort stable.
  always_comb begin
    do_swap = !a_eq_b && (DESCENDING ? a_ls_b : a_grt_b);
  end

  // Working registers after the current compare step, swap applied.
  always_comb begin
    r0_d = r0_q;
    r1_d = r1_q;
    r2_d = r2_q;
    r3_d = r3_q;
    if (do_swap) begin
      case (pair_sel)
        2'd1: begin
          r1_d = r2_q;
          r2_d = r1_q;
        end
        2'd2: begin
          r2_d = r3_q;
          r3_d = r2_q;
        end
        default: begin
          r0_d = r1_q;
          r1_d = r0_q;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      step_q     <= 3'd0;
      r0_q       <= 4'd0;
      r1_q       <= 4'd0;
      r2_q       <= 4'd0;
      r3_q       <= 4'd0;
      swap_cnt_q <= 3'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        // DONE accepts Start exactly like IDLE for back-to-back sorts.
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.Start) begin
            r0_q       <= bus.D0;
            r1_q       <= bus.D1;
            r2_q       <= bus.D2;
            r3_q       <= bus.D3;
            swap_cnt_q <= 3'd0;
            step_q     <= 3'd0;
            busy_q     <= 1'b1;
            state_q    <= CMP;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        CMP: begin
          if (step_q == LAST_STEP) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            r0_q   <= r0_d;
            r1_q   <= r1_d;
            r2_q   <= r2_d;
            r3_q   <= r3_d;
            step_q <= step_q + 3'd1;
            if (do_swap) begin
              swap_cnt_q <= swap_cnt_q + 3'd1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
  assign bus.Q0        = r0_q;
  assign bus.Q1        = r1_q;
  assign bus.Q2        = r2_q;
  assign bus.Q3        = r3_q;
  assign bus.SwapCount = swap_cnt_q;

endmodule
